// File: rtl/imm_pack_if.sv
// +--------------------------------------------------------------------------+
// | imm_pack_if : value-in / word-out handshake bundle for imm_pack           |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

interface imm_pack_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_value;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_eop;
  logic [15:0] out_imm;
  logic        out_last;

  modport master (
    output in_valid, in_value, out_ready,
    input  in_ready, out_valid, out_eop, out_imm, out_last
  );

  modport slave (
    input  in_valid, in_value, out_ready,
    output in_ready, out_valid, out_eop, out_imm, out_last
  );
endinterface

`default_nettype wire

// File: rtl/imm_pack.sv
// +--------------------------------------------------------------------------+
// | imm_pack : 32-bit constant -> shortest (EOp, imm16) word sequence        |
// | Optional macro IMM_PACK_SHIFT_FORM_EN enables the one-word EOp 11 form.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module imm_pack #(
  parameter int CNT_W = 16
) (
  input  wire logic             clk,
  input  wire logic             reset_n,
  imm_pack_if.slave             bus,
  output      logic [CNT_W-1:0] pair_cnt
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] EMIT1 = 2'd1;
  localparam logic [1:0] EMIT2 = 2'd2;

  localparam logic [1:0] EOP_SEXT  = 2'b00;
  localparam logic [1:0] EOP_ZEXT  = 2'b01;
  localparam logic [1:0] EOP_UPPER = 2'b10;
  localparam logic [1:0] EOP_SHIFT = 2'b11;

  logic [1:0]  state;
  logic [1:0]  eop_q;
  logic [15:0] imm_q;
  logic        last_q;
  logic [15:0] lo_hold;

  logic [1:0]  cls_eop;
  logic [15:0] cls_imm;
  logic        cls_last;
  logic        cls_pair;
  logic [31:0] v;

  assign v = bus.in_value;

  // First matching rule wins; the default is the lui+ori pair.
  always_comb begin
    cls_eop  = EOP_UPPER;
    cls_imm  = v[31:16];
    cls_last = 1'b0;
    cls_pair = 1'b1;
    if ((&v[31:15]) || !(|v[31:15])) begin
      cls_eop  = EOP_SEXT;
      cls_imm  = v[15:0];
      cls_last = 1'b1;
      cls_pair = 1'b0;
    end else if (v[31:16] == 16'h0000) begin
      cls_eop  = EOP_ZEXT;
      cls_imm  = v[15:0];
      cls_last = 1'b1;
      cls_pair = 1'b0;
    end else if (v[15:0] == 16'h0000) begin
      cls_eop  = EOP_UPPER;
      cls_imm  = v[31:16];
      cls_last = 1'b1;
      cls_pair = 1'b0;
    end
`ifdef IMM_PACK_SHIFT_FORM_EN
    else if ((v[1:0] == 2'b00) && ((&v[31:17]) || !(|v[31:17]))) begin
      cls_eop  = EOP_SHIFT;
      cls_imm  = v[17:2];
      cls_last = 1'b1;
      cls_pair = 1'b0;
    end
`endif
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state != IDLE);
  assign bus.out_eop   = eop_q;
  assign bus.out_imm   = imm_q;
  assign bus.out_last  = last_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      eop_q    <= 2'b00;
      imm_q    <= 16'h0000;
      last_q   <= 1'b0;
      lo_hold  <= 16'h0000;
      pair_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            state   <= EMIT1;
            eop_q   <= cls_eop;
            imm_q   <= cls_imm;
            last_q  <= cls_last;
            lo_hold <= v[15:0];
            if (cls_pair && (pair_cnt != {CNT_W{1'b1}}))
              pair_cnt <= pair_cnt + 1'b1;
          end
        end
        EMIT1: begin
          if (bus.out_ready) begin
            if (last_q) begin
              state <= IDLE;
            end else begin
              state  <= EMIT2;
              eop_q  <= EOP_ZEXT;
              imm_q  <= lo_hold;
              last_q <= 1'b1;
            end
          end
        end
        EMIT2: begin
          if (bus.out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_imm_pack.sv
// +--------------------------------------------------------------------------+
// | tb_imm_pack : scoreboard bench for imm_pack (CNT_W=4 build)              |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_imm_pack;

  localparam int CNT_W = 4;
`ifdef IMM_PACK_SHIFT_FORM_EN
  localparam bit SHIFT_EN = 1'b1;
`else
  localparam bit SHIFT_EN = 1'b0;
`endif
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic clk;
  logic reset_n;
  logic [CNT_W-1:0] pair_cnt;

  imm_pack_if bus ();

  imm_pack #(.CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .pair_cnt (pair_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  logic [18:0] sb[$];
  logic [CNT_W-1:0] exp_pairs;

  // Reference extender: what the decode side rebuilds from one word.
  function automatic logic [31:0] ext(input logic [1:0] m, input logic [15:0] i);
    case (m)
      2'b00:   ext = {{16{i[15]}}, i};
      2'b01:   ext = {16'h0000, i};
      2'b10:   ext = {i, 16'h0000};
      default: ext = {{14{i[15]}}, i, 2'b00};
    endcase
  endfunction

  // Scoreboard: each word that fires is compared with the oldest expectation.
  always @(negedge clk) begin
    if (reset_n && bus.out_valid && bus.out_ready) begin
      total++;
      if (sb.size() == 0) begin
        $display("FAIL word_unexpected: got eop=%b imm=%h last=%b, none expected",
                 bus.out_eop, bus.out_imm, bus.out_last);
      end else begin
        logic [18:0] e;
        e = sb.pop_front();
        if ({bus.out_eop, bus.out_imm, bus.out_last} !== e)
          $display("FAIL word: got eop=%b imm=%h last=%b, expected eop=%b imm=%h last=%b",
                   bus.out_eop, bus.out_imm, bus.out_last, e[18:17], e[16:1], e[0]);
        else
          passed++;
      end
    end
  end

  task automatic expect_value(input logic [31:0] v);
    if (ext(2'b00, v[15:0]) == v)
      sb.push_back({2'b00, v[15:0], 1'b1});
    else if (ext(2'b01, v[15:0]) == v)
      sb.push_back({2'b01, v[15:0], 1'b1});
    else if (ext(2'b10, v[31:16]) == v)
      sb.push_back({2'b10, v[31:16], 1'b1});
    else if (SHIFT_EN && (ext(2'b11, v[17:2]) == v))
      sb.push_back({2'b11, v[17:2], 1'b1});
    else begin
      sb.push_back({2'b10, v[31:16], 1'b0});
      sb.push_back({2'b01, v[15:0], 1'b1});
      if (exp_pairs != CNT_MAX) exp_pairs = exp_pairs + 1'b1;
    end
  endtask

  // Entered and left at posedge+1; holds in_valid until the DUT accepts.
  task automatic push(input logic [31:0] v);
    int n;
    logic acc;
    expect_value(v);
    bus.in_valid = 1'b1;
    bus.in_value = v;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 200) begin
      acc = bus.in_ready;
      @(posedge clk); #1;
      n++;
    end
    if (!acc) begin
      total++;
      $display("FAIL accept_timeout: value=%h in_ready=%b, required accept", v, bus.in_ready);
    end
    bus.in_valid = 1'b0;
    bus.in_value = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || !bus.in_ready) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (sb.size() != 0 || !bus.in_ready)
      $display("FAIL drain_timeout: pending=%0d in_ready=%b, required 0/1", sb.size(), bus.in_ready);
    else
      passed++;
  endtask

  task automatic check_cnt(input string name);
    total++;
    if (pair_cnt !== exp_pairs)
      $display("FAIL %s: pair_cnt=%0d, expected %0d", name, pair_cnt, exp_pairs);
    else
      passed++;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    sb.delete();
    exp_pairs = '0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.in_value = 32'h0;
    bus.out_ready = 1'b1;
    reset_n = 1'b0;
    exp_pairs = '0;
    #12;
    total++;
    if ({bus.in_ready, bus.out_valid, bus.out_eop, bus.out_imm, bus.out_last, pair_cnt} !==
        {1'b1, 1'b0, 2'b00, 16'h0000, 1'b0, {CNT_W{1'b0}}})
      $display("FAIL reset_state: rdy=%b vld=%b eop=%b imm=%h last=%b cnt=%0d, expected 1 0 00 0000 0 0",
               bus.in_ready, bus.out_valid, bus.out_eop, bus.out_imm, bus.out_last, pair_cnt);
    else
      passed++;
    do_reset();
  endtask

  task automatic test_latency();
    bus.out_ready = 1'b1;
    push(32'h0000_0000);
    total++;
    if ({bus.out_valid, bus.in_ready} !== 2'b10)
      $display("FAIL latency_n1: out_valid=%b in_ready=%b, expected 1 0", bus.out_valid, bus.in_ready);
    else
      passed++;
    @(posedge clk); #1;
    total++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01)
      $display("FAIL latency_n2: out_valid=%b in_ready=%b, expected 0 1", bus.out_valid, bus.in_ready);
    else
      passed++;
    check_cnt("latency_cnt");
  endtask

  task automatic test_single();
    bus.out_ready = 1'b1;
    push(32'h0000_FFFF);
    push(32'hFFFF_8000);
    push(32'hFFFF_0000);
    push(32'h0000_7FFF);
    push(32'h8000_0000);
    drain();
    check_cnt("single_cnt");
  endtask

  task automatic test_pair();
    bus.out_ready = 1'b1;
    push(32'h1234_5678);
    total++;
    if ({bus.out_valid, bus.out_last} !== 2'b10)
      $display("FAIL pair_first: out_valid=%b last=%b, expected 1 0", bus.out_valid, bus.out_last);
    else
      passed++;
    @(posedge clk); #1;
    total++;
    if ({bus.out_valid, bus.out_last, bus.out_imm} !== {2'b11, 16'h5678})
      $display("FAIL pair_second: out_valid=%b last=%b imm=%h, expected 1 1 5678",
               bus.out_valid, bus.out_last, bus.out_imm);
    else
      passed++;
    drain();
    check_cnt("pair_cnt");
  endtask

  task automatic test_shift_form();
    bus.out_ready = 1'b1;
    push(32'h0001_FFFC);
    push(32'hFFFE_0004);
    drain();
    check_cnt("shift_cnt");
  endtask

  task automatic test_backpressure();
    logic [18:0] held;
    bus.out_ready = 1'b0;
    push(32'hDEAD_BEEF);
    held = {bus.out_eop, bus.out_imm, bus.out_last};
    for (int k = 0; k < 5; k++) begin
      total++;
      if ({bus.out_valid, bus.in_ready, bus.out_eop, bus.out_imm, bus.out_last} !==
          {1'b1, 1'b0, 2'b10, 16'hDEAD, 1'b0} || {bus.out_eop, bus.out_imm, bus.out_last} !== held)
        $display("FAIL stall_hold[%0d]: vld=%b rdy=%b eop=%b imm=%h last=%b, expected 1 0 10 dead 0",
                 k, bus.out_valid, bus.in_ready, bus.out_eop, bus.out_imm, bus.out_last);
      else
        passed++;
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    total++;
    if ({bus.out_valid, bus.out_eop, bus.out_imm, bus.out_last} !== {1'b1, 2'b01, 16'hBEEF, 1'b1})
      $display("FAIL emit2_word: vld=%b eop=%b imm=%h last=%b, expected 1 01 beef 1",
               bus.out_valid, bus.out_eop, bus.out_imm, bus.out_last);
    else
      passed++;
    #2 reset_n = 1'b0;
    #1;
    total++;
    if ({bus.out_valid, bus.in_ready, pair_cnt} !== {1'b0, 1'b1, {CNT_W{1'b0}}})
      $display("FAIL async_reset: out_valid=%b in_ready=%b pair_cnt=%0d, expected 0 1 0",
               bus.out_valid, bus.in_ready, pair_cnt);
    else
      passed++;
    bus.out_ready = 1'b1;
    do_reset();
  endtask

  function automatic logic [31:0] gen();
    logic [15:0] r;
    r = 16'($urandom);
    case ($urandom_range(0, 4))
      0:       gen = {{16{r[15]}}, r};
      1:       gen = {16'h0000, r};
      2:       gen = {r, 16'h0000};
      3:       gen = {{14{r[15]}}, r, 2'b00};
      default: gen = $urandom;
    endcase
  endfunction

  task automatic test_back_to_back();
    bit done;
    done = 1'b0;
    fork
      begin
        for (int k = 0; k < 40; k++) push(gen());
        done = 1'b1;
      end
      begin
        while (!done) begin
          bus.out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
      end
    join
    bus.out_ready = 1'b1;
    drain();
    check_cnt("b2b_cnt");
  endtask

  task automatic test_saturate();
    bus.out_ready = 1'b1;
    do_reset();
    for (int k = 0; k < 15; k++) push(32'h1234_0001 + 32'(k));
    drain();
    check_cnt("sat_15");
    push(32'h4321_0001);
    drain();
    check_cnt("sat_16");
    push(32'h7654_0003);
    drain();
    check_cnt("sat_17");
  endtask

  initial begin
    test_reset();
    test_latency();
    test_single();
    test_pair();
    test_shift_form();
    test_backpressure();
    test_back_to_back();
    test_saturate();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
